pll_reconfig_ctrl: RTL and testbench

//  Run-time controller for a Gowin PLL used with dynamic output dividers (DYN_ODIVn_SEL="TRUE").
//  - Drives ODSELn and RESET; filters LOCK.
//  - Accepts new divider sets through a valid/ready handshake, e.g. an RGMII 1000/100/10 speed switch.
//  - Sequences per-domain resets so downstream logic only runs on locked clocks.
//  - Sits beside the PLL wrapper in the clocking tile; wrapper ODSEL/RESET/LOCK connect straight to it.

---
 rtl/pll_reconfig_ctrl_pkg.sv | 21 ++
 rtl/pll_reconfig_ctrl_lock_filter.sv | 38 +++
 rtl/pll_reconfig_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reconfig_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration controller.
package pll_ctrl_pkg;

  localparam int PLL_DIV_W    = 7;
  localparam int PLL_MAX_OUT  = 7;
  localparam int RELOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    ASSERT_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    ERROR
  } pll_state_e;

  // Saturating increment for the lock-loss event counter
  function automatic logic [RELOCK_CNT_W-1:0] relock_inc(input logic [RELOCK_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pll_reconfig_ctrl_lock_filter.sv
// PLL LOCK synchroniser and debounce: 2-FF sync followed by a saturating
// run-length counter; lock_ok once LOCK_FILT consecutive synced-high cycles seen.
module pll_lock_filter #(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock,
  output logic lock_sync,
  output logic lock_ok
);

  localparam int CNT_W = $clog2(LOCK_FILT + 1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;

  // Synchronise raw LOCK and count consecutive high cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= pll_lock;
      r_sync <= r_meta;
      if (!r_sync)
        r_cnt <= '0;
      else if (r_cnt != CNT_W'(LOCK_FILT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign lock_sync = r_sync;
  assign lock_ok   = (r_cnt == CNT_W'(LOCK_FILT));

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Run-time controller for a Gowin PLL with dynamic output dividers: drives
// ODSEL/RESET, filters LOCK, accepts divider sets over valid/ready and
// sequences per-domain resets.
// Optional feature macro PLL_AUTO_RELOCK_EN: lock loss in RUN restarts the
// PLL with the current dividers instead of parking in ERROR.
module pll_reconfig_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int NUM_OUT   = 2,
  parameter int DIV_W     = PLL_DIV_W,
  parameter logic [NUM_OUT-1:0][DIV_W-1:0] DEF_DIV = {7'd14, 7'd70},
  parameter int RST_HOLD  = 8,
  parameter int LOCK_FILT = 16,
  parameter int LOCK_TMO  = 65535,
  parameter int MAX_RETRY = 3,
  parameter int REL_GAP   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [NUM_OUT*DIV_W-1:0] cfg_div,
  output logic                     pll_reset,
  output logic [NUM_OUT*DIV_W-1:0] pll_odsel,
  input  logic                     pll_lock,
  output logic [NUM_OUT-1:0]       domain_rst_n,
  output logic                     locked,
  output logic                     err,
  output logic [RELOCK_CNT_W-1:0]  relock_cnt
);

  localparam int REL_SPAN = REL_GAP * (NUM_OUT - 1);
  localparam int CNT_MAX  = (LOCK_TMO > RST_HOLD)
                          ? ((LOCK_TMO > REL_SPAN) ? LOCK_TMO : REL_SPAN)
                          : ((RST_HOLD > REL_SPAN) ? RST_HOLD : REL_SPAN);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  pll_state_e                    r_state;
  logic [CNT_W-1:0]              r_cnt;
  logic [RTY_W-1:0]              r_retry;
  logic                          r_pll_reset;
  logic [NUM_OUT-1:0][DIV_W-1:0] r_odsel;
  logic [NUM_OUT-1:0]            r_dom;
  logic                          r_cfg_ready;
  logic                          r_locked;
  logic                          r_err;
  logic [RELOCK_CNT_W-1:0]       r_relock;

  logic                          w_lock_sync;
  logic                          w_lock_ok;
  logic                          w_accept;
  logic [NUM_OUT-1:0][DIV_W-1:0] w_cfg_div;

  pll_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .lock_sync (w_lock_sync),
    .lock_ok   (w_lock_ok)
  );

  assign w_accept = cfg_valid && r_cfg_ready && (r_state == RUN || r_state == ERROR);

  // Unpack requested dividers, forcing a zero divider up to 1
  always_comb begin
    w_cfg_div = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      w_cfg_div[i] = (cfg_div[i*DIV_W +: DIV_W] == '0) ? DIV_W'(1) : cfg_div[i*DIV_W +: DIV_W];
    end
  end

  // Control FSM: reset hold, lock wait with retries, staged domain release, run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ASSERT_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_odsel     <= DEF_DIV;
      r_dom       <= '0;
      r_cfg_ready <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_relock    <= '0;
    end else if (w_accept) begin
      // Accept takes priority over a coincident lock loss, so relock_cnt is untouched
      r_state     <= ASSERT_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_pll_reset <= 1'b1;
      r_odsel     <= w_cfg_div;
      r_dom       <= '0;
      r_cfg_ready <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ASSERT_RST: begin
          if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
            r_state     <= WAIT_LOCK;
            r_pll_reset <= 1'b0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (w_lock_ok) begin
            r_state <= RELEASE;
            r_retry <= '0;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(LOCK_TMO - 1)) begin
            r_cnt       <= '0;
            r_retry     <= r_retry + 1'b1;
            r_pll_reset <= 1'b1;
            if (r_retry == RTY_W'(MAX_RETRY - 1)) begin
              r_state     <= ERROR;
              r_err       <= 1'b1;
              r_cfg_ready <= 1'b1;
            end else begin
              r_state <= ASSERT_RST;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!w_lock_sync) begin
            r_state     <= ASSERT_RST;
            r_pll_reset <= 1'b1;
            r_dom       <= '0;
            r_cnt       <= '0;
          end else begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
              if (r_cnt == CNT_W'(REL_GAP * i))
                r_dom[i] <= 1'b1;
            end
            if (r_cnt == CNT_W'(REL_SPAN)) begin
              r_state     <= RUN;
              r_locked    <= 1'b1;
              r_cfg_ready <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!w_lock_sync) begin
            r_dom       <= '0;
            r_locked    <= 1'b0;
            r_relock    <= relock_inc(r_relock);
            r_pll_reset <= 1'b1;
            r_cnt       <= '0;
`ifdef PLL_AUTO_RELOCK_EN
            r_state     <= ASSERT_RST;
            r_cfg_ready <= 1'b0;
`else
            r_state     <= ERROR;
            r_err       <= 1'b1;
`endif
          end
        end
        ERROR: begin
          r_pll_reset <= 1'b1;
          r_dom       <= '0;
        end
        default: begin
          r_state     <= ASSERT_RST;
          r_pll_reset <= 1'b1;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign cfg_ready    = r_cfg_ready;
  assign pll_reset    = r_pll_reset;
  assign pll_odsel    = r_odsel;
  assign domain_rst_n = r_dom;
  assign locked       = r_locked;
  assign err          = r_err;
  assign relock_cnt   = r_relock;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with a simple PLL model that raises
// LOCK 20 cycles after RESET falls.
module tb_pll_reconfig_ctrl;

  localparam int W = 14;
  localparam logic [W-1:0] DEF = {7'd14, 7'd70};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_div = '0;
  logic         cfg_ready;
  logic         pll_reset;
  logic [W-1:0] pll_odsel;
  logic         pll_lock;
  logic [1:0]   domain_rst_n;
  logic         locked;
  logic         err;
  logic [7:0]   relock_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic lock_allow = 1'b1;
  logic glitch = 1'b0;
  int   lk_cnt = 0;

  always #5 clk = ~clk;

  // PLL model: LOCK rises 20 cycles after RESET is released
  always @(negedge clk) begin
    if (pll_reset || !lock_allow) lk_cnt = 0;
    else if (lk_cnt < 20) lk_cnt = lk_cnt + 1;
  end
  assign pll_lock = (lk_cnt >= 20) && !glitch;

  pll_reconfig_ctrl #(
    .NUM_OUT   (2),
    .DIV_W     (7),
    .DEF_DIV   ({7'd14, 7'd70}),
    .RST_HOLD  (8),
    .LOCK_FILT (16),
    .LOCK_TMO  (100),
    .MAX_RETRY (3),
    .REL_GAP   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .pll_reset    (pll_reset),
    .pll_odsel    (pll_odsel),
    .pll_lock     (pll_lock),
    .domain_rst_n (domain_rst_n),
    .locked       (locked),
    .err          (err),
    .relock_cnt   (relock_cnt)
  );

  task automatic measure_high(output int n);
    n = 0;
    while (pll_reset === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic measure_low(output int n);
    n = 0;
    while (pll_reset === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Called on the first sample with pll_reset low; follows the release sequence into RUN
  task automatic run_to_lock(input string tag);
    int t = 0, t0 = -1, t1 = -1, tl = -1;
    while (t < 300 && tl < 0) begin
      if (t0 < 0 && domain_rst_n[0] === 1'b1) t0 = t;
      if (t1 < 0 && domain_rst_n[1] === 1'b1) t1 = t;
      if (tl < 0 && locked === 1'b1) tl = t;
      if (tl < 0) begin
        @(negedge clk);
        t++;
      end
    end
    vectors++;
    if (t0 !== 39) begin miscompares++; $display("FAIL %s_dom0_time got %0d exp 39", tag, t0); end
    vectors++;
    if (t1 - t0 !== 4) begin miscompares++; $display("FAIL %s_dom_gap got %0d exp 4", tag, t1 - t0); end
    vectors++;
    if (tl !== t1) begin miscompares++; $display("FAIL %s_locked_time got %0d exp %0d", tag, tl, t1); end
    vectors++;
    if (domain_rst_n !== 2'b11 || cfg_ready !== 1'b1 || pll_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_run_outputs got dom=%b rdy=%b rst=%b exp dom=11 rdy=1 rst=0",
               tag, domain_rst_n, cfg_ready, pll_reset);
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if (pll_reset !== 1'b1 || pll_odsel !== DEF || domain_rst_n !== 2'b00 || cfg_ready !== 1'b0 ||
        locked !== 1'b0 || err !== 1'b0 || relock_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL %s got rst=%b odsel=%h dom=%b rdy=%b lck=%b err=%b cnt=%0d exp rst=1 odsel=%h dom=00 rdy=0 lck=0 err=0 cnt=0",
               tag, pll_reset, pll_odsel, domain_rst_n, cfg_ready, locked, err, relock_cnt, DEF);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_values");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_powerup;
    int n;
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL pwr_reset_len got %0d exp 8", n); end
    run_to_lock("pwr");
    vectors++;
    if (pll_odsel !== DEF) begin miscompares++; $display("FAIL pwr_odsel got %h exp %h", pll_odsel, DEF); end
    vectors++;
    if (err !== 1'b0 || relock_cnt !== 8'd0) begin
      miscompares++; $display("FAIL pwr_err_cnt got err=%b cnt=%0d exp err=0 cnt=0", err, relock_cnt);
    end
  endtask

  task automatic test_cfg_update;
    int n;
    cfg_div = {7'd5, 7'd0};
    cfg_valid = 1'b1;
    vectors++;
    if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL cfg_ready_run got %b exp 1", cfg_ready); end
    @(negedge clk);
    cfg_valid = 1'b0;
    vectors++;
    if (cfg_ready !== 1'b0 || pll_odsel !== {7'd5, 7'd1} || domain_rst_n !== 2'b00 ||
        locked !== 1'b0 || pll_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_accept got rdy=%b odsel=%h dom=%b lck=%b rst=%b exp rdy=0 odsel=%h dom=00 lck=0 rst=1",
               cfg_ready, pll_odsel, domain_rst_n, locked, pll_reset, {7'd5, 7'd1});
    end
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL cfg_reset_len got %0d exp 8", n); end
    run_to_lock("cfg");
    vectors++;
    if (pll_odsel !== {7'd5, 7'd1} || relock_cnt !== 8'd0) begin
      miscompares++; $display("FAIL cfg_final got odsel=%h cnt=%0d exp odsel=%h cnt=0", pll_odsel, relock_cnt, {7'd5, 7'd1});
    end
  endtask

  task automatic test_no_lock;
    int n;
    lock_allow = 1'b0;
    cfg_div = DEF;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      measure_high(n);
      vectors++;
      if (n !== 8) begin miscompares++; $display("FAIL nolock_pulse%0d got %0d exp 8", p, n); end
      measure_low(n);
      vectors++;
      if (n !== 100) begin miscompares++; $display("FAIL nolock_wait%0d got %0d exp 100", p, n); end
      vectors++;
      if (err !== (p == 2)) begin miscompares++; $display("FAIL nolock_err%0d got %b exp %b", p, err, (p == 2)); end
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (cfg_ready !== 1'b1 || pll_reset !== 1'b1 || domain_rst_n !== 2'b00 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL nolock_error_state got rdy=%b rst=%b dom=%b err=%b exp rdy=1 rst=1 dom=00 err=1",
               cfg_ready, pll_reset, domain_rst_n, err);
    end
  endtask

  task automatic test_lock_glitch;
    int n;
    lock_allow = 1'b1;
    cfg_div = DEF;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL glitch_err_clear got %b exp 0", err); end
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL glitch_restart_len got %0d exp 8", n); end
    run_to_lock("glitch_pre");
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    @(negedge clk);
    vectors++;
    if (locked !== 1'b1) begin miscompares++; $display("FAIL glitch_sync_delay got %b exp 1", locked); end
    @(negedge clk);
    vectors++;
    if (relock_cnt !== 8'd1 || locked !== 1'b0 || domain_rst_n !== 2'b00 || pll_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_loss got cnt=%0d lck=%b dom=%b rst=%b exp cnt=1 lck=0 dom=00 rst=1",
               relock_cnt, locked, domain_rst_n, pll_reset);
    end
`ifdef PLL_AUTO_RELOCK_EN
    vectors++;
    if (err !== 1'b0 || cfg_ready !== 1'b0) begin
      miscompares++; $display("FAIL glitch_auto got err=%b rdy=%b exp err=0 rdy=0", err, cfg_ready);
    end
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL glitch_auto_len got %0d exp 8", n); end
    run_to_lock("glitch_auto");
`else
    vectors++;
    if (err !== 1'b1 || cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL glitch_err got err=%b rdy=%b exp err=1 rdy=1", err, cfg_ready);
    end
    repeat (50) @(negedge clk);
    vectors++;
    if (pll_reset !== 1'b1 || err !== 1'b1 || domain_rst_n !== 2'b00) begin
      miscompares++; $display("FAIL glitch_hold got rst=%b err=%b dom=%b exp rst=1 err=1 dom=00", pll_reset, err, domain_rst_n);
    end
    cfg_div = DEF;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL glitch_recfg_err got %b exp 0", err); end
    measure_high(n);
    run_to_lock("glitch_recfg");
`endif
    vectors++;
    if (relock_cnt !== 8'd1) begin miscompares++; $display("FAIL glitch_cnt_final got %0d exp 1", relock_cnt); end
  endtask

  task automatic test_cfg_vs_loss;
    int n;
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    @(negedge clk);
    cfg_div = {7'd3, 7'd9};
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    vectors++;
    if (pll_odsel !== {7'd3, 7'd9} || relock_cnt !== 8'd1 || err !== 1'b0 ||
        cfg_ready !== 1'b0 || pll_reset !== 1'b1) begin
      miscompares++;
      $display("FAIL both_accept got odsel=%h cnt=%0d err=%b rdy=%b rst=%b exp odsel=%h cnt=1 err=0 rdy=0 rst=1",
               pll_odsel, relock_cnt, err, cfg_ready, pll_reset, {7'd3, 7'd9});
    end
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL both_reset_len got %0d exp 8", n); end
    run_to_lock("both");
    vectors++;
    if (pll_odsel !== {7'd3, 7'd9} || relock_cnt !== 8'd1) begin
      miscompares++; $display("FAIL both_final got odsel=%h cnt=%0d exp odsel=%h cnt=1", pll_odsel, relock_cnt, {7'd3, 7'd9});
    end
  endtask

  task automatic test_async_reset;
    int n;
    int k = 0;
    cfg_div = {7'd5, 7'd0};
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    measure_high(n);
    while (domain_rst_n !== 2'b01 && k < 200) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (domain_rst_n !== 2'b01) begin miscompares++; $display("FAIL areset_in_release got %b exp 01", domain_rst_n); end
    #2 rst_n = 1'b0;
    #1 check_reset_values("areset_values");
    @(negedge clk);
    rst_n = 1'b1;
    measure_high(n);
    vectors++;
    if (n !== 8) begin miscompares++; $display("FAIL areset_reset_len got %0d exp 8", n); end
    run_to_lock("areset");
    vectors++;
    if (pll_odsel !== DEF) begin miscompares++; $display("FAIL areset_odsel got %h exp %h", pll_odsel, DEF); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_cfg_update();
    test_no_lock();
    test_lock_glitch();
    test_cfg_vs_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
